// File: rtl/clm_multiplier_digit_serial.sv
// Digit-serial masked GF(2^8) multiplier in the redundant CLM representation.
// Operands are kept modulo M = (x^8+P)(x^D+q). W bits of operand a are
// consumed per cycle. The accumulator and the shifter are re-randomised with
// r*(x^8+P) every cycle, so the result is only defined modulo x^8+P.
module clm_multiplier_digit_serial #(
   parameter int unsigned D       = 4,
   parameter int unsigned W       = 2,
   parameter bit          REFRESH = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [8+D-1:0] a,
   input  logic [8+D-1:0] b,
   input  logic [7:0]     P,
   input  logic [D-1:0]   q,
   input  logic [D-1:0]   rand_acc,
   input  logic [D-1:0]   rand_shf,
   output logic           rand_req_o,
   output logic [8+D-1:0] out,
   output logic           valid_o
);

   localparam int unsigned L  = 8 + D;
   localparam int unsigned N  = (L + W - 1) / W;
   localparam int unsigned AW = N * W;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // r * (x^8 + p): the degree stays below L, so no reduction is needed
   function automatic logic [L-1:0] mul_fp(input logic [7:0] p, input logic [D-1:0] r);
      logic [L-1:0] pf;
      logic [L-1:0] prod;
      pf   = L'({1'b1, p});
      prod = '0;
      for (int unsigned i = 0; i < D; i++) begin
         if (r[i]) prod = prod ^ (pf << i);
      end
      return prod;
   endfunction

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  a_q, a_d;
   logic [L-1:0]   shf_q, shf_d;
   logic [L-1:0]   acc_q, acc_d;
   logic [L-1:0]   m_q, m_d;
   logic [7:0]     p_q, p_d;
   logic [L-1:0]   out_q, out_d;
   logic           ready_q, ready_d;
   logic           valid_q, valid_d;
   logic           rand_req_q, rand_req_d;

   logic [L-1:0]   m_in;
   logic [L-1:0]   c_v;
   logic [L-1:0]   s_v;
   logic [L-1:0]   acc_nx;
   logic [L-1:0]   shf_nx;
   logic           accept;

   // Reduction modulus: low L bits of (x^8+P)(x^D+q); the x^(8+D) term drops out
   always_comb begin
      m_in = (L'(P) << D) ^ mul_fp(P, q);
   end

   // One RUN cycle: W unrolled multiply-and-shift steps, then refresh
   // a_q is shifted right by W each cycle, so bit j is always digit bit k = cnt*W + j;
   // the zero padding above bit L-1 makes the last partial digit contribute nothing.
   always_comb begin
      c_v = acc_q;
      s_v = shf_q;
      for (int unsigned j = 0; j < W; j++) begin
         if (a_q[j]) c_v = c_v ^ s_v;
         s_v = {s_v[L-2:0], 1'b0} ^ (s_v[L-1] ? m_q : '0);
      end
      acc_nx = c_v ^ (REFRESH ? mul_fp(p_q, rand_acc) : '0);
      shf_nx = s_v ^ (REFRESH ? mul_fp(p_q, rand_shf) : '0);
   end

   // Control: next state, operand capture and registered handshake outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      shf_d      = shf_q;
      acc_d      = acc_q;
      m_d        = m_q;
      p_d        = p_q;
      out_d      = out_q;
      ready_d    = ready_q;
      valid_d    = 1'b0;
      rand_req_d = rand_req_q;
      accept     = valid_i && ready_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               a_d        = AW'(a);
               shf_d      = b;
               acc_d      = '0;
               m_d        = m_in;
               p_d        = P;
               cnt_d      = '0;
               state_d    = RUN;
               ready_d    = 1'b0;
               rand_req_d = 1'b1;
            end else begin
               state_d    = IDLE;
               ready_d    = 1'b1;
               rand_req_d = 1'b0;
            end
         end
         RUN: begin
            acc_d = acc_nx;
            shf_d = shf_nx;
            a_d   = a_q >> W;
            if (cnt_q == CW'(N - 1)) begin
               state_d    = DONE;
               out_d      = acc_nx;
               valid_d    = 1'b1;
               ready_d    = 1'b1;
               rand_req_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            ready_d    = 1'b1;
            rand_req_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         shf_q      <= '0;
         acc_q      <= '0;
         m_q        <= '0;
         p_q        <= '0;
         out_q      <= '0;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         rand_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         shf_q      <= shf_d;
         acc_q      <= acc_d;
         m_q        <= m_d;
         p_q        <= p_d;
         out_q      <= out_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         rand_req_q <= rand_req_d;
      end
   end

   assign ready_o    = ready_q;
   assign valid_o    = valid_q;
   assign rand_req_o = rand_req_q;
   assign out        = out_q;

endmodule

// File: tb/tb_clm_multiplier_digit_serial.sv
// Self-checking bench for clm_multiplier_digit_serial (D=4).
// Reference: plain polynomial arithmetic. Exact out = (a*b + sum r_s(t)*Pf*(a>>tW)) mod M
// plus sum r_a(t)*Pf; field result = (a mod Pf)*(b mod Pf) mod Pf.
module tb_clm_multiplier_digit_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [11:0] a_i, b_i;
   logic [7:0]  p_i;
   logic [3:0]  q_i, ra_i, rs_i;

   logic        ready_w2, rreq_w2, valid_w2;
   logic [11:0] out_w2;
   logic        ready_w1, rreq_w1, valid_w1;
   logic [11:0] out_w1;
   logic        ready_w3, rreq_w3, valid_w3;
   logic [11:0] out_w3;
   logic        ready_w12, rreq_w12, valid_w12;
   logic [11:0] out_w12;

   int n_cmp = 0;
   int n_bad = 0;
   int rmode = 0;
   logic [3:0] ra_hist [0:63];
   logic [3:0] rs_hist [0:63];

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [7:0]  p;
      logic [3:0]  q;
      logic [7:0]  gf;
   } vec_t;
   vec_t vecs [0:7];

   always #5 clk = ~clk;

   clm_multiplier_digit_serial #(.D(4), .W(2), .REFRESH(1'b1)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w2), .a(a_i), .b(b_i),
      .P(p_i), .q(q_i), .rand_acc(ra_i), .rand_shf(rs_i), .rand_req_o(rreq_w2),
      .out(out_w2), .valid_o(valid_w2));

   clm_multiplier_digit_serial #(.D(4), .W(1), .REFRESH(1'b1)) dut_w1 (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w1), .a(a_i), .b(b_i),
      .P(p_i), .q(q_i), .rand_acc(ra_i), .rand_shf(rs_i), .rand_req_o(rreq_w1),
      .out(out_w1), .valid_o(valid_w1));

   clm_multiplier_digit_serial #(.D(4), .W(3), .REFRESH(1'b1)) dut_w3 (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w3), .a(a_i), .b(b_i),
      .P(p_i), .q(q_i), .rand_acc(ra_i), .rand_shf(rs_i), .rand_req_o(rreq_w3),
      .out(out_w3), .valid_o(valid_w3));

   clm_multiplier_digit_serial #(.D(4), .W(12), .REFRESH(1'b1)) dut_w12 (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w12), .a(a_i), .b(b_i),
      .P(p_i), .q(q_i), .rand_acc(ra_i), .rand_shf(rs_i), .rand_req_o(rreq_w12),
      .out(out_w12), .valid_o(valid_w12));

   function automatic logic [31:0] clmul(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (y[i]) r = r ^ (x << i);
      end
      return r;
   endfunction

   function automatic logic [31:0] pmod(input logic [31:0] x, input logic [31:0] m);
      logic [31:0] v;
      int dm;
      v  = x;
      dm = 0;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) dm = i;
      end
      for (int i = 31; i >= dm; i--) begin
         if (v[i]) v = v ^ (m << (i - dm));
      end
      return v;
   endfunction

   function automatic logic [31:0] gfmul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] p);
      logic [31:0] pf;
      pf = 32'h100 | p;
      return pmod(clmul(pmod(a, pf), pmod(b, pf)), pf);
   endfunction

   function automatic logic [31:0] exact_out(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] p, input logic [31:0] q,
                                             input int w, input int n);
      logic [31:0] pf, m, sum, racc;
      pf   = 32'h100 | p;
      m    = clmul(pf, 32'h10 | q);
      sum  = clmul(a, b);
      racc = '0;
      for (int t = 1; t <= n; t++) begin
         sum  = sum ^ clmul(clmul(32'(rs_hist[t]), pf), a >> (t * w));
         racc = racc ^ clmul(32'(ra_hist[t]), pf);
      end
      return pmod(sum, m) ^ racc;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic check_ne(input string name, input logic [31:0] got, input logic [31:0] other);
      n_cmp++;
      if (got === other) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected a value different from %0h", name, got, other);
      end
   endtask

   // Rand values driven here are consumed at the clock edge ending RUN cycle t.
   task automatic drive_rand(input int t, input int n);
      logic [3:0] ra, rs;
      case (rmode)
         1: begin ra = 4'($urandom); rs = 4'($urandom); end
         2: begin ra = (t == n) ? 4'h9 : 4'h0; rs = 4'h0; end
         default: begin ra = 4'h0; rs = 4'h0; end
      endcase
      ra_i = ra;
      rs_i = rs;
      ra_hist[t] = ra;
      rs_hist[t] = rs;
   endtask

   task automatic start_op(input logic [11:0] a, input logic [11:0] b,
                           input logic [7:0] p, input logic [3:0] q);
      @(negedge clk);
      check("ready_idle", 32'(ready_w2), 32'd1);
      check("valid_idle", 32'(valid_w2), 32'd0);
      a_i = a; b_i = b; p_i = p; q_i = q;
      valid_i = 1'b1;
      @(posedge clk);
   endtask

   task automatic collect(input int n, input bit scr, output int lat);
      lat = 0;
      for (int t = 1; t <= 40 && lat == 0; t++) begin
         @(negedge clk);
         if (t == 1) valid_i = 1'b0;
         if (valid_w2 === 1'b1) begin
            lat = t;
         end else begin
            check("ready_run", 32'(ready_w2), 32'd0);
            check("rand_req_run", 32'(rreq_w2), 32'd1);
            drive_rand(t, n);
            if (scr) begin
               a_i = 12'($urandom); b_i = 12'($urandom);
               p_i = 8'($urandom);  q_i = 4'($urandom);
            end
         end
      end
   endtask

   task automatic do_op(input logic [11:0] a, input logic [11:0] b, input logic [7:0] p,
                        input logic [3:0] q, input bit scr, output logic [11:0] res);
      int lat;
      start_op(a, b, p, q);
      collect(6, scr, lat);
      check("latency", 32'(lat), 32'd7);
      res = out_w2;
      check("exact", 32'(out_w2), exact_out(32'(a), 32'(b), 32'(p), 32'(q), 2, 6));
      check("mod_p", pmod(32'(out_w2), 32'h100 | 32'(p)), gfmul(32'(a), 32'(b), 32'(p)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] res, unref, first;
      int lat, lat2, l1, l3, l12, l2;
      logic [11:0] r1, r3, r12, r2;
      logic [11:0] sa, sb;
      logic [7:0]  sp;
      logic [3:0]  sq;

      vecs[0] = '{12'h057, 12'h083, 8'h1B, 4'h0, 8'hC1};
      vecs[1] = '{12'h002, 12'h087, 8'h1B, 4'h0, 8'h15};
      vecs[2] = '{12'h057, 12'h013, 8'h1B, 4'hB, 8'hFE};
      vecs[3] = '{12'h053, 12'h0CA, 8'h1B, 4'h3, 8'h01};
      vecs[4] = '{12'h000, 12'h0FF, 8'h1B, 4'h5, 8'h00};
      vecs[5] = '{12'h001, 12'h0AB, 8'h1B, 4'h0, 8'hAB};
      vecs[6] = '{12'h100, 12'h001, 8'h1B, 4'h7, 8'h1B};
      vecs[7] = '{12'hFFF, 12'h001, 8'h1B, 4'hF, 8'h66};

      rst = 1'b1; valid_i = 1'b0;
      a_i = '0; b_i = '0; p_i = '0; q_i = '0; ra_i = '0; rs_i = '0;
      #1;
      check("rst_out", 32'(out_w2), 32'd0);
      check("rst_valid", 32'(valid_w2), 32'd0);
      check("rst_rand_req", 32'(rreq_w2), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(ready_w2), 32'd1);

      // Table vectors, no refresh
      rmode = 0;
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].q, 1'b0, res);
         check("tbl_gf", pmod(32'(res), 32'h100 | 32'(vecs[i].p)), 32'(vecs[i].gf));
      end

      // Refresh changes the redundant form, not the field value
      rmode = 0;
      do_op(12'h057, 12'h083, 8'h1B, 4'hB, 1'b0, unref);
      rmode = 2;
      do_op(12'h057, 12'h083, 8'h1B, 4'hB, 1'b0, res);
      check_ne("refresh_differs", 32'(res), 32'(unref));
      check("refresh_gf", pmod(32'(res), 32'h11B), 32'hC1);
      rmode = 1;
      do_op(12'h057, 12'h083, 8'h1B, 4'hB, 1'b0, res);
      check("refresh_rand_gf", pmod(32'(res), 32'h11B), 32'hC1);

      // Inputs scrambled every RUN cycle
      do_op(12'h3A7, 12'h9C4, 8'h1B, 4'h6, 1'b1, res);

      // Back-to-back with valid_i held high
      rmode = 0;
      @(negedge clk);
      check("b2b_ready", 32'(ready_w2), 32'd1);
      a_i = 12'h057; b_i = 12'h083; p_i = 8'h1B; q_i = 4'h0; valid_i = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int t = 1; t <= 40 && lat == 0; t++) begin
         @(negedge clk);
         if (t == 1) begin a_i = 12'h002; b_i = 12'h087; end
         if (valid_w2 === 1'b1) lat = t;
         else drive_rand(t, 6);
      end
      check("b2b_lat1", 32'(lat), 32'd7);
      first = out_w2;
      check("b2b_gf1", pmod(32'(first), 32'h11B), 32'hC1);
      check("b2b_exact1", 32'(first), exact_out(32'h057, 32'h083, 32'h1B, 32'h0, 2, 6));
      check("b2b_ready_done", 32'(ready_w2), 32'd1);
      @(posedge clk);
      lat2 = 0;
      for (int t = 1; t <= 40 && lat2 == 0; t++) begin
         @(negedge clk);
         if (t == 1) valid_i = 1'b0;
         if (valid_w2 === 1'b1) begin
            lat2 = t;
         end else begin
            check("b2b_out_stable", 32'(out_w2), 32'(first));
            drive_rand(t, 6);
         end
      end
      check("b2b_lat2", 32'(lat2), 32'd7);
      check("b2b_gf2", pmod(32'(out_w2), 32'h11B), 32'h15);
      check("b2b_exact2", 32'(out_w2), exact_out(32'h002, 32'h087, 32'h1B, 32'h0, 2, 6));

      // Reset in the 3rd RUN cycle
      rmode = 1;
      start_op(12'h0A5, 12'h03C, 8'h1B, 4'h6);
      for (int t = 1; t <= 3; t++) begin
         @(negedge clk);
         if (t == 1) valid_i = 1'b0;
         drive_rand(t, 6);
      end
      rst = 1'b1;
      #1;
      check("midrst_out", 32'(out_w2), 32'd0);
      check("midrst_valid", 32'(valid_w2), 32'd0);
      check("midrst_ready", 32'(ready_w2), 32'd1);
      check("midrst_rand_req", 32'(rreq_w2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         check("no_valid_after_rst", 32'(valid_w2), 32'd0);
      end

      // Digit-width sweep: all instances idle, accept on the same edge
      sa = 12'h9E3; sb = 12'h5B1; sp = 8'h1B; sq = 4'hD;
      @(negedge clk);
      a_i = sa; b_i = sb; p_i = sp; q_i = sq; valid_i = 1'b1;
      @(posedge clk);
      l1 = 0; l3 = 0; l12 = 0; l2 = 0;
      r1 = '0; r3 = '0; r12 = '0; r2 = '0;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         if (t == 1) valid_i = 1'b0;
         if (valid_w1 === 1'b1 && l1 == 0) begin l1 = t; r1 = out_w1; end
         if (valid_w3 === 1'b1 && l3 == 0) begin l3 = t; r3 = out_w3; end
         if (valid_w12 === 1'b1 && l12 == 0) begin l12 = t; r12 = out_w12; end
         if (valid_w2 === 1'b1 && l2 == 0) begin l2 = t; r2 = out_w2; end
         drive_rand(t, 20);
      end
      check("sweep_lat_w1", 32'(l1), 32'd13);
      check("sweep_lat_w3", 32'(l3), 32'd5);
      check("sweep_lat_w12", 32'(l12), 32'd2);
      check("sweep_lat_w2", 32'(l2), 32'd7);
      check("sweep_exact_w1", 32'(r1), exact_out(32'(sa), 32'(sb), 32'(sp), 32'(sq), 1, 12));
      check("sweep_exact_w3", 32'(r3), exact_out(32'(sa), 32'(sb), 32'(sp), 32'(sq), 3, 4));
      check("sweep_exact_w12", 32'(r12), exact_out(32'(sa), 32'(sb), 32'(sp), 32'(sq), 12, 1));
      check("sweep_exact_w2", 32'(r2), exact_out(32'(sa), 32'(sb), 32'(sp), 32'(sq), 2, 6));
      check("sweep_gf_w1", pmod(32'(r1), 32'h11B), gfmul(32'(sa), 32'(sb), 32'(sp)));
      check("sweep_gf_w3", pmod(32'(r3), 32'h11B), gfmul(32'(sa), 32'(sb), 32'(sp)));
      check("sweep_gf_w12", pmod(32'(r12), 32'h11B), gfmul(32'(sa), 32'(sb), 32'(sp)));

      // Random operations with random refresh masks
      rmode = 1;
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] rp;
         rp = (i % 2 == 0) ? 8'h1B : 8'($urandom);
         do_op(12'($urandom), 12'($urandom), rp, 4'($urandom), 1'($urandom), res);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
